sfp_cage_ctrl: RTL
==================

// Module: sfp_cage_ctrl
//
// PURPOSE
// Per-cage SFP management sequencer; one instance per cage (sfp1, sfp2).
// - Debounces the module-present and loss-of-signal pins.
// - Applies the SFP init wait after insertion, then drives tx_dis.
// - Handles TX_FAULT with bounded retry and lockout.
// - Reports link and fault status to the board status logic (LEDs, debug).
//
// PARAMETERS
// DEBOUNCE_CYC     1_000_000   stable cycles before mod_abs/rxlos change is accepted (10 ms @100 MHz)
// INSERT_WAIT_CYC  30_000_000  tx_dis hold after insertion or enable (300 ms, SFP t_init)
// FAULT_HOLD_CYC   1_000       tx_dis assertion per fault-reset attempt (10 us)
// MAX_RETRIES      3           fault-reset attempts before lockout, range 1..7
//
// PORTS
// clk          in   1  single clock, 100 MHz user clock domain
// rst_n        in   1  asynchronous active-low reset
// mod_abs_i    in   1  cage MOD_ABS pin, async; 1 = no module
// rxlos_i      in   1  cage RX_LOS pin, async; 1 = no optical signal
// txflt_i      in   1  cage TX_FAULT pin, async; 1 = laser fault
// en_i         in   1  software enable for the cage
// rate_sel_i   in   2  {rs1,rs0} requested rate select
// tx_dis_o     out  1  to cage TX_DISABLE; 1 = laser off
// rs_o         out  2  to cage {RS1,RS0}
// state_o      out  3  current FSM state encoding
// link_up_o    out  1  1 only while in LINK_UP
// fault_o      out  1  1 only while in FAULT_LOCK
// retry_cnt_o  out  3  fault-reset attempts since the last clear
// insert_evt_o out  1  one-cycle pulse on ABSENT -> INIT_WAIT
//
// BEHAVIOUR
// Reset values:
// - tx_dis_o=1, rs_o=2'b00, state_o=ABSENT, all other outputs 0.
// - Debounced mod_abs and rxlos reset to 1.
// Input conditioning:
// - mod_abs_i, rxlos_i, txflt_i each pass through a 2-FF synchronizer.
// - mod_abs and rxlos are debounced: a new level is accepted only after DEBOUNCE_CYC
//   consecutive synced samples differ from the held value; any matching sample clears
//   the counter.
// - txflt is used synced, not debounced.
// - Pin edge to FSM state change takes exactly DEBOUNCE_CYC+3 clocks for debounced
//   inputs, and exactly 3 clocks for txflt.
// rs_o: registers rate_sel_i every cycle, 1-cycle latency. Forced to 0 in ABSENT.
// State encoding and behaviour:
// - ABSENT=0: tx_dis=1.
//   Leaves when debounced mod_abs=0: goes to DISABLED if en_i=0, otherwise to
//   INIT_WAIT and pulses insert_evt_o.
// - INIT_WAIT=1: tx_dis=1, wait counter runs.
//   After INSERT_WAIT_CYC cycles in the state, goes to TX_ON.
// - TX_ON=2: tx_dis=0.
//   Goes to FAULT_RESET on txflt=1, otherwise to LINK_UP on debounced rxlos=0.
// - LINK_UP=3: tx_dis=0.
//   Goes to FAULT_RESET on txflt=1, otherwise back to TX_ON on debounced rxlos=1.
// - FAULT_RESET=4: tx_dis=1; retry_cnt increments on entry.
//   After FAULT_HOLD_CYC cycles, goes to FAULT_LOCK if retry_cnt==MAX_RETRIES,
//   otherwise to TX_ON.
// - FAULT_LOCK=5: tx_dis=1, fault_o=1.
//   Left only by removal, by en_i=0, or by reset.
// - DISABLED=6: tx_dis=1.
//   Goes to INIT_WAIT when en_i=1; insert_evt_o does not pulse.
// Global overrides, highest priority first:
// 1. Debounced mod_abs=1 from any state: go to ABSENT.
// 2. en_i=0 from any non-ABSENT state: go to DISABLED.
// 3. The state-local transitions above.
// Counters and retries:
// - The wait counter clears on every state change.
// - retry_cnt clears on entry to ABSENT or DISABLED only; it saturates at MAX_RETRIES.
// - A txflt pulse during INIT_WAIT or FAULT_RESET is ignored.
// - rxlos changes while in FAULT_RESET are tracked by the debouncer; they do not
//   alter the transition out of FAULT_RESET.
// - Simultaneous txflt=1 and rxlos drop in TX_ON: FAULT_RESET wins.
// - Reset asserted mid-operation: all outputs return immediately (async) to their
//   reset values.
//
// TESTING (DEBOUNCE_CYC=4, INSERT_WAIT_CYC=20, FAULT_HOLD_CYC=5, MAX_RETRIES=2, en_i=1)
// 1. Insert: mod_abs_i 1->0 at cycle 0 -> insert_evt_o single pulse, state=1 at cycle 7;
//    state=2 and tx_dis_o=0 at cycle 27.
// 2. Glitch: mod_abs_i low for 3 cycles only -> state stays 0, no insert_evt_o,
//    tx_dis_o stays 1.
// 3. Link: in TX_ON, drop rxlos_i -> state=3 and link_up_o=1 after 7 cycles;
//    raise rxlos_i -> back to 2.
// 4. Fault retry: from LINK_UP, hold txflt_i=1 -> FAULT_RESET for 5 cycles
//    (retry_cnt_o=1), then TX_ON, then FAULT_RESET again (retry_cnt_o=2), then
//    FAULT_LOCK: fault_o=1, tx_dis_o=1.
// 5. Recovery: in FAULT_LOCK, pulse en_i=0 for 1 cycle -> state=6 and retry_cnt_o=0;
//    then INIT_WAIT; TX_ON 20 cycles later.
// 6. Removal and reset mid-run: mod_abs_i=1 in LINK_UP -> state=0 and rs_o=0 after
//    7 cycles; assert rst_n low during INIT_WAIT -> state=0 and tx_dis_o=1 with no
//    clock edge.

Source files
------------

// File: rtl/sfp_cage_ctrl.sv
// Per-cage SFP management sequencer: pin synchronisation and debounce, insertion
// wait, TX_FAULT retry/lockout, and registered status outputs.
module sfp_cage_ctrl #(
    parameter int unsigned DEBOUNCE_CYC    = 1_000_000,
    parameter int unsigned INSERT_WAIT_CYC = 30_000_000,
    parameter int unsigned FAULT_HOLD_CYC  = 1_000,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mod_abs_i,
    input  logic       rxlos_i,
    input  logic       txflt_i,
    input  logic       en_i,
    input  logic [1:0] rate_sel_i,
    output logic       tx_dis_o,
    output logic [1:0] rs_o,
    output logic [2:0] state_o,
    output logic       link_up_o,
    output logic       fault_o,
    output logic [2:0] retry_cnt_o,
    output logic       insert_evt_o
);

    typedef enum logic [2:0] {
        ST_ABSENT      = 3'd0,
        ST_INIT_WAIT   = 3'd1,
        ST_TX_ON       = 3'd2,
        ST_LINK_UP     = 3'd3,
        ST_FAULT_RESET = 3'd4,
        ST_FAULT_LOCK  = 3'd5,
        ST_DISABLED    = 3'd6
    } state_e;

    localparam int unsigned DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned WAIT_MAX = (INSERT_WAIT_CYC > FAULT_HOLD_CYC) ? INSERT_WAIT_CYC
                                                                          : FAULT_HOLD_CYC;
    localparam int unsigned WT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    // Bit 0 = mod_abs, bit 1 = rxlos, bit 2 = txflt.
    logic [2:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0][DB_W-1:0]  dbcnt_q, dbcnt_d;

    state_e                state_q, state_d;
    logic [WT_W-1:0]       wait_q, wait_d;
    logic [2:0]            retry_q, retry_d;
    logic                  tx_dis_q, tx_dis_d;
    logic [1:0]            rs_q, rs_d;
    logic                  link_q, link_d;
    logic                  fault_q, fault_d;
    logic                  ins_q, ins_d;

    logic                  mod_abs_db, rxlos_db, txflt_s;

    assign mod_abs_db = deb_q[0];
    assign rxlos_db   = deb_q[1];
    assign txflt_s    = sync2_q[2];

    always_comb begin
        deb_d   = deb_q;
        dbcnt_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (dbcnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dbcnt_d[i] = dbcnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (mod_abs_db) begin
            state_d = ST_ABSENT;
        end else if (!en_i && state_q != ST_ABSENT) begin
            state_d = ST_DISABLED;
        end else begin
            unique case (state_q)
                ST_ABSENT:      state_d = en_i ? ST_INIT_WAIT : ST_DISABLED;
                ST_INIT_WAIT:   if (wait_q == WT_W'(INSERT_WAIT_CYC - 1)) state_d = ST_TX_ON;
                ST_TX_ON:       if (txflt_s) state_d = ST_FAULT_RESET;
                                else if (!rxlos_db) state_d = ST_LINK_UP;
                ST_LINK_UP:     if (txflt_s) state_d = ST_FAULT_RESET;
                                else if (rxlos_db) state_d = ST_TX_ON;
                ST_FAULT_RESET: if (wait_q == WT_W'(FAULT_HOLD_CYC - 1))
                                    state_d = (retry_q == 3'(MAX_RETRIES)) ? ST_FAULT_LOCK
                                                                           : ST_TX_ON;
                ST_FAULT_LOCK:  state_d = ST_FAULT_LOCK;
                ST_DISABLED:    state_d = ST_INIT_WAIT;
                default:        state_d = ST_ABSENT;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_comb begin
        wait_d  = '0;
        retry_d = retry_q;
        if (state_d != state_q) begin
            if (state_d == ST_ABSENT || state_d == ST_DISABLED) begin
                retry_d = '0;
            end else if (state_d == ST_FAULT_RESET && retry_q != 3'(MAX_RETRIES)) begin
                retry_d = retry_q + 3'd1;
            end
        end else if (state_q == ST_INIT_WAIT || state_q == ST_FAULT_RESET) begin
            wait_d = wait_q + WT_W'(1);
        end
        tx_dis_d = !(state_d == ST_TX_ON || state_d == ST_LINK_UP);
        link_d   = (state_d == ST_LINK_UP);
        fault_d  = (state_d == ST_FAULT_LOCK);
        ins_d    = (state_q == ST_ABSENT) && (state_d == ST_INIT_WAIT);
        rs_d     = (state_d == ST_ABSENT) ? 2'b00 : rate_sel_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 3'b011;
            sync2_q  <= 3'b011;
            deb_q    <= '1;
            dbcnt_q  <= '0;
            state_q  <= ST_ABSENT;
            wait_q   <= '0;
            retry_q  <= '0;
            tx_dis_q <= 1'b1;
            rs_q     <= '0;
            link_q   <= 1'b0;
            fault_q  <= 1'b0;
            ins_q    <= 1'b0;
        end else begin
            sync1_q  <= {txflt_i, rxlos_i, mod_abs_i};
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            dbcnt_q  <= dbcnt_d;
            state_q  <= state_d;
            wait_q   <= wait_d;
            retry_q  <= retry_d;
            tx_dis_q <= tx_dis_d;
            rs_q     <= rs_d;
            link_q   <= link_d;
            fault_q  <= fault_d;
            ins_q    <= ins_d;
        end
    end

    assign tx_dis_o     = tx_dis_q;
    assign rs_o         = rs_q;
    assign state_o      = state_q;
    assign link_up_o    = link_q;
    assign fault_o      = fault_q;
    assign retry_cnt_o  = retry_q;
    assign insert_evt_o = ins_q;

endmodule
